bk_kbd_buffer: RTL and testbench
================================

// Module: bk_kbd_buffer
// PURPOSE
//  Keyboard-side provider for the CPU keyboard registers (0177660/0177662). Accepts decoded
//  make/break strobes from the key decoder and queues codes in a small FIFO. Presents the head
//  as kbd_data/kbd_available/kbd_ar2, and pops when the CPU finishes reading the data register.
//  Also generates typematic auto-repeat and the keydown level used by register 0177716.
// PARAMETERS
//  DEPTH         8     FIFO entries; power of 2, >=2
//  REPEAT_DELAY  8000  ce ticks from make to first repeat; 0 disables auto-repeat
//  REPEAT_RATE   1000  ce ticks between subsequent repeats; >=1
// PORTS
//  m_clock        in   1  system clock; all state on posedge
//  p_reset        in   1  synchronous, active-high reset
//  ce             in   1  clock enable; FIFO/pop/repeat logic advances only when ce=1
//  key_strobe     in   1  one-m_clock pulse: key event valid (sampled every m_clock, ce ignored)
//  key_make       in   1  with strobe: 1=press, 0=release
//  key_code       in   7  BK (KOI-7) code of the event
//  key_ar2        in   1  with strobe: AR2 modifier held (selects vector 0274)
//  read_kbd       in   1  CPU address decode of 0177662; level, may span many cycles
//  kbd_data       out  8  {1'b0, code} of current head; holds last value when empty
//  kbd_available  out  1  FIFO non-empty (CPU "done" bit 7)
//  kbd_ar2        out  1  AR2 flag of entry shown on kbd_data
//  keydown        out  1  1 while a key is held (repeat-tracked key)
//  overflow       out  1  one-ce-cycle pulse when a push is dropped (FIFO full)
// BEHAVIOUR
//  Reset: FIFO empty, kbd_data=0, kbd_available=0, kbd_ar2=0, keydown=0, overflow=0,
//   pending=0, repeat counter=0, read_q=0. Reset overrides strobe, pending push and pop.
//  Capture: key_strobe latches {make,code,ar2} into a 1-deep pending reg on any m_clock;
//   a second strobe before it is consumed overwrites it (decoder rate << ce rate, by contract).
//  Pending consumed on next ce=1 cycle:
//   make  -> push {ar2,code}; held_code<=code, held_ar2<=ar2, keydown<=1,
//            rep_cnt<=REPEAT_DELAY.
//   break -> if code==held_code: keydown<=0, repeat stops; else ignored. No push.
//  Auto-repeat (REPEAT_DELAY!=0, keydown=1, no make consumed this cycle): rep_cnt decrements
//   per ce; on the ce tick it reaches 0, push {held_ar2,held_code} and reload REPEAT_RATE.
//   Make and repeat push same cycle: make wins, repeat push suppressed.
//  Pop: read_q<=read_kbd each ce; pop on ce cycle with read_q=1 & read_kbd=0 (trailing edge),
//   so data is stable for the whole CPU bus cycle. Pop while empty: no effect.
//  Output regs: kbd_data/kbd_ar2 update on the ce cycle after any push-into-empty or pop,
//   showing the new head; if the FIFO became empty they keep the popped value.
//  Latency: make consumed on ce cycle N -> kbd_available=1 and kbd_data valid at N+1.
//  Full: push with count==DEPTH and no simultaneous pop is dropped; overflow=1 that cycle.
//  Push+pop same cycle: both done, count unchanged; if full, push accepted (pop frees slot).
//  Pointers are log2(DEPTH)+1 bits, wrap naturally; empty = ptrs equal, full = MSB differs.
//  ce=0: all registers except pending capture hold; outputs stable.
// TESTING
//  1 make 0x41 ar2=0 -> next ce cycle kbd_available=1, kbd_data=0x41, kbd_ar2=0, keydown=1.
//  2 read_kbd high 5 cycles then low -> exactly one pop; kbd_available=0; kbd_data stays 0x41.
//  3 DEPTH+1 makes w/o read -> count=DEPTH, overflow pulses once, first DEPTH codes read in order.
//  4 REPEAT_DELAY=4, RATE=2, hold 0x20 12 ce -> pushes at ce 0,4,6,8,10; break 0x20 stops.
//  5 break of non-held code 0x33 while 0x20 held -> keydown stays 1, repeat continues.
//  6 p_reset during repeat with 3 entries queued -> all outputs 0 next cycle, no further pushes.

Source files
------------

// File: rtl/bk_kbd_buffer_if.sv
// bk_kbd_buffer_if
//   Groups the key-decoder strobes, the CPU read decode and the register-side outputs of the
//   keyboard buffer into one bundle.
//   master : drives key_strobe/key_make/key_code/key_ar2/read_kbd, observes the outputs
//   slave  : the buffer itself (bk_kbd_buffer)
//   Signals
//     key_strobe    one-clock pulse: key event valid
//     key_make      1=press, 0=release (with strobe)
//     key_code[6:0] KOI-7 code of the event
//     key_ar2       AR2 modifier held (with strobe)
//     read_kbd      CPU is reading the keyboard data register (level)
//     kbd_data[7:0] {1'b0, code} of the current head
//     kbd_available FIFO non-empty
//     kbd_ar2       AR2 flag of the entry shown on kbd_data
//     keydown       a key is held
//     overflow      one-ce-cycle pulse when a push was dropped
interface bk_kbd_buffer_if;
   logic       key_strobe;
   logic       key_make;
   logic [6:0] key_code;
   logic       key_ar2;
   logic       read_kbd;
   logic [7:0] kbd_data;
   logic       kbd_available;
   logic       kbd_ar2;
   logic       keydown;
   logic       overflow;

   modport master (
      output key_strobe,
      output key_make,
      output key_code,
      output key_ar2,
      output read_kbd,
      input  kbd_data,
      input  kbd_available,
      input  kbd_ar2,
      input  keydown,
      input  overflow
   );

   modport slave (
      input  key_strobe,
      input  key_make,
      input  key_code,
      input  key_ar2,
      input  read_kbd,
      output kbd_data,
      output kbd_available,
      output kbd_ar2,
      output keydown,
      output overflow
   );
endinterface

// File: rtl/bk_kbd_buffer.sv
// bk_kbd_buffer
//   Keyboard-side provider for the CPU keyboard registers 0177660/0177662. Key events from the
//   decoder are latched into a one-deep pending register, consumed on the next ce cycle and
//   queued in a small FIFO. The FIFO head is presented as kbd_data/kbd_available/kbd_ar2 and
//   is popped on the trailing edge of the CPU read. A held key generates typematic repeats.
//   Ports
//     i_m_clock   system clock, all state on posedge
//     i_p_reset   synchronous active-high reset
//     i_ce        clock enable for FIFO, pop and repeat logic (pending capture ignores it)
//     bus         bk_kbd_buffer_if.slave: key strobes, read decode and register outputs
module bk_kbd_buffer #(
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned REPEAT_DELAY = 8000,
   parameter int unsigned REPEAT_RATE  = 1000
) (
   input logic            i_m_clock,
   input logic            i_p_reset,
   input logic            i_ce,
   bk_kbd_buffer_if.slave bus
);

   localparam int unsigned AW     = $clog2(DEPTH);
   localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned CntW   = $clog2(RepMax + 1);
   localparam bit          RepEn  = (REPEAT_DELAY != 0);

   // pending event from the decoder
   logic            r_pend_valid;
   logic            r_pend_make;
   logic [6:0]      r_pend_code;
   logic            r_pend_ar2;

   // FIFO: entries are {ar2, code}
   logic [7:0]      r_mem [DEPTH];
   logic [AW:0]     r_wr_ptr;
   logic [AW:0]     r_rd_ptr;

   // held key / typematic state
   logic [6:0]      r_held_code;
   logic            r_held_ar2;
   logic            r_keydown;
   logic [CntW-1:0] r_rep_cnt;

   // CPU side
   logic            r_read_q;
   logic [6:0]      r_kbd_code;
   logic            r_kbd_ar2;
   logic            r_kbd_avail;
   logic            r_overflow;

   logic            w_empty;
   logic            w_full;
   logic            w_make;
   logic            w_brk_match;
   logic            w_rep_fire;
   logic            w_push;
   logic            w_push_ok;
   logic            w_pop;
   logic            w_overflow;
   logic [7:0]      w_push_data;
   logic [AW-1:0]   w_wr_idx;
   logic [AW-1:0]   w_rd_idx;

   always_comb begin
      w_wr_idx    = r_wr_ptr[AW-1:0];
      w_rd_idx    = r_rd_ptr[AW-1:0];
      w_empty     = (r_wr_ptr == r_rd_ptr);
      w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
      w_make      = i_ce & r_pend_valid & r_pend_make;
      w_brk_match = i_ce & r_pend_valid & ~r_pend_make & (r_pend_code == r_held_code);
      // a matching release stops the repeat in the very cycle it is consumed
      w_rep_fire  = RepEn & i_ce & r_keydown & ~w_make & ~w_brk_match
                    & (r_rep_cnt == CntW'(1));
      w_push      = w_make | w_rep_fire;
      w_push_data = w_make ? {r_pend_ar2, r_pend_code} : {r_held_ar2, r_held_code};
      // trailing edge of the CPU read, so data stays stable for the whole bus cycle
      w_pop       = i_ce & r_read_q & ~bus.read_kbd & ~w_empty;
      w_push_ok   = w_push & (~w_full | w_pop);
      w_overflow  = w_push & w_full & ~w_pop;
   end

   // pending capture runs every clock; ce only governs consumption
   always_ff @(posedge i_m_clock) begin
      if (i_p_reset) begin
         r_pend_valid <= 1'b0;
         r_pend_make  <= 1'b0;
         r_pend_code  <= '0;
         r_pend_ar2   <= 1'b0;
      end else if (bus.key_strobe) begin
         r_pend_valid <= 1'b1;
         r_pend_make  <= bus.key_make;
         r_pend_code  <= bus.key_code;
         r_pend_ar2   <= bus.key_ar2;
      end else if (i_ce) begin
         r_pend_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_m_clock) begin
      if (!i_p_reset && w_push_ok) begin
         r_mem[w_wr_idx] <= w_push_data;
      end
   end

   always_ff @(posedge i_m_clock) begin
      if (i_p_reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_held_code <= '0;
         r_held_ar2  <= 1'b0;
         r_keydown   <= 1'b0;
         r_rep_cnt   <= '0;
         r_read_q    <= 1'b0;
         r_kbd_code  <= '0;
         r_kbd_ar2   <= 1'b0;
         r_kbd_avail <= 1'b0;
         r_overflow  <= 1'b0;
      end else if (i_ce) begin
         r_read_q   <= bus.read_kbd;
         r_overflow <= w_overflow;

         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end

         // Output registers track the head one ce cycle behind; the head only changes on a
         // push into empty or a pop, so refreshing every cycle is equivalent. When empty the
         // last shown value is kept.
         r_kbd_avail <= ~w_empty;
         if (!w_empty) begin
            {r_kbd_ar2, r_kbd_code} <= r_mem[w_rd_idx];
         end

         if (w_make) begin
            r_held_code <= r_pend_code;
            r_held_ar2  <= r_pend_ar2;
            r_keydown   <= 1'b1;
            r_rep_cnt   <= CntW'(REPEAT_DELAY);
         end else if (w_brk_match) begin
            r_keydown <= 1'b0;
            r_rep_cnt <= '0;
         end else if (RepEn && r_keydown) begin
            if (r_rep_cnt == CntW'(1)) begin
               r_rep_cnt <= CntW'(REPEAT_RATE);
            end else begin
               r_rep_cnt <= r_rep_cnt - 1'b1;
            end
         end
      end
   end

   assign bus.kbd_data      = {1'b0, r_kbd_code};
   assign bus.kbd_available = r_kbd_avail;
   assign bus.kbd_ar2       = r_kbd_ar2;
   assign bus.keydown       = r_keydown;
   assign bus.overflow      = r_overflow;

endmodule

// File: tb/tb_bk_kbd_buffer.sv
// tb_bk_kbd_buffer
//   Self-checking bench for bk_kbd_buffer. A queue-based reference model tracks the FIFO
//   contents, the held key and the absolute ce tick of the next repeat; register outputs are
//   modelled as the queue head as it stood before each ce tick.
module tb_bk_kbd_buffer;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned DELAY = 4;
   localparam int unsigned RATE  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   bk_kbd_buffer_if bus ();

   bk_kbd_buffer #(
      .DEPTH        (DEPTH),
      .REPEAT_DELAY (DELAY),
      .REPEAT_RATE  (RATE)
   ) dut (
      .i_m_clock (clk),
      .i_p_reset (rst),
      .i_ce      (ce),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [7:0] m_q [$];
   bit         m_pend_v;
   bit         m_pend_make;
   logic [6:0] m_pend_code;
   bit         m_pend_ar2;
   logic [6:0] m_held_code;
   bit         m_held_ar2;
   bit         m_keydown;
   bit         m_read_q;
   int         m_tick;
   int         m_next_rep;
   logic [6:0] m_data;
   bit         m_ar2;
   bit         m_avail;
   bit         m_ovf;

   function automatic logic [11:0] dut_vec();
      return {bus.kbd_data, bus.kbd_available, bus.kbd_ar2, bus.keydown, bus.overflow};
   endfunction

   function automatic logic [11:0] mdl_vec();
      return {1'b0, m_data, m_avail, m_ar2, m_keydown, m_ovf};
   endfunction

   // advance the model by one clock edge using the inputs currently driven
   task automatic model_update();
      logic [7:0] pushv;
      bit         do_push;
      bit         mk;
      bit         brk;
      bit         pop;
      if (rst) begin
         m_q.delete();
         m_pend_v = 0; m_pend_make = 0; m_pend_code = '0; m_pend_ar2 = 0;
         m_held_code = '0; m_held_ar2 = 0; m_keydown = 0; m_read_q = 0;
         m_tick = 0; m_next_rep = 0;
         m_data = '0; m_ar2 = 0; m_avail = 0; m_ovf = 0;
         return;
      end
      if (ce) begin
         m_tick++;
         m_avail = (m_q.size() != 0);
         if (m_avail) begin
            m_data = m_q[0][6:0];
            m_ar2  = m_q[0][7];
         end
         mk      = m_pend_v && m_pend_make;
         brk     = m_pend_v && !m_pend_make && (m_pend_code == m_held_code);
         do_push = 0;
         pushv   = '0;
         if (mk) begin
            pushv       = {m_pend_ar2, m_pend_code};
            do_push     = 1;
            m_held_code = m_pend_code;
            m_held_ar2  = m_pend_ar2;
            m_keydown   = 1;
            m_next_rep  = m_tick + int'(DELAY);
         end else if (brk) begin
            m_keydown = 0;
         end else if (m_keydown && DELAY != 0 && m_tick == m_next_rep) begin
            pushv      = {m_held_ar2, m_held_code};
            do_push    = 1;
            m_next_rep = m_tick + int'(RATE);
         end
         pop   = m_read_q && !bus.read_kbd && (m_q.size() != 0);
         m_ovf = 0;
         if (pop) void'(m_q.pop_front());
         if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(pushv);
            else m_ovf = 1;
         end
         m_read_q = bus.read_kbd;
      end
      if (bus.key_strobe) begin
         m_pend_v    = 1;
         m_pend_make = bus.key_make;
         m_pend_code = bus.key_code;
         m_pend_ar2  = bus.key_ar2;
      end else if (ce) begin
         m_pend_v = 0;
      end
   endtask

   task automatic step(input logic ce_v);
      ce = ce_v;
      model_update();
      @(posedge clk);
      #1;
      bus.key_strobe = 1'b0;
   endtask

   task automatic key(input bit mk, input logic [6:0] c, input bit a);
      bus.key_strobe = 1'b1;
      bus.key_make   = mk;
      bus.key_code   = c;
      bus.key_ar2    = a;
   endtask

   // one complete CPU read of the data register; outputs are refreshed on return
   task automatic read_one();
      bus.read_kbd = 1'b1;
      step(1); step(1);
      bus.read_kbd = 1'b0;
      step(1); step(1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(1); step(1);
      if (dut_vec() !== 12'h000) begin
         $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 12'h000);
      end else n_pass++;
      n_checks++;
      rst = 1'b0;
      step(1);
      if (dut_vec() !== mdl_vec()) begin
         $display("FAIL reset_idle: got %h expected %h", dut_vec(), mdl_vec());
      end else n_pass++;
      n_checks++;
   endtask

   task automatic test_single_make();
      key(1, 7'h41, 0);
      step(1);                        // captured
      step(1);                        // consumed and pushed
      if (bus.keydown !== 1'b1) begin
         $display("FAIL make_keydown: got %b expected 1", bus.keydown);
      end else n_pass++;
      n_checks++;
      key(0, 7'h41, 0);
      step(1);                        // outputs now show the head
      if ({bus.kbd_available, bus.kbd_data, bus.kbd_ar2} !== {1'b1, 8'h41, 1'b0}) begin
         $display("FAIL make_latency: got avail=%b data=%h ar2=%b expected 1 41 0",
                  bus.kbd_available, bus.kbd_data, bus.kbd_ar2);
      end else n_pass++;
      n_checks++;
      step(1);                        // release consumed
      if (dut_vec() !== mdl_vec()) begin
         $display("FAIL make_release: got %h expected %h", dut_vec(), mdl_vec());
      end else n_pass++;
      n_checks++;
   endtask

   task automatic test_read_pop();
      key(1, 7'h42, 1); step(1); step(1);
      key(0, 7'h42, 1); step(1); step(1);
      bus.read_kbd = 1'b1;
      for (int i = 0; i < 5; i++) step(1);
      bus.read_kbd = 1'b0;
      step(1); step(1); step(1);
      if ({bus.kbd_available, bus.kbd_data, bus.kbd_ar2} !== {1'b1, 8'h42, 1'b1}) begin
         $display("FAIL read_single_pop: got avail=%b data=%h ar2=%b expected 1 42 1",
                  bus.kbd_available, bus.kbd_data, bus.kbd_ar2);
      end else n_pass++;
      n_checks++;
      read_one();
      if ({bus.kbd_available, bus.kbd_data} !== {1'b0, 8'h42}) begin
         $display("FAIL read_empty_hold: got avail=%b data=%h expected 0 42",
                  bus.kbd_available, bus.kbd_data);
      end else n_pass++;
      n_checks++;
      read_one();                     // pop while empty does nothing
      if (dut_vec() !== mdl_vec()) begin
         $display("FAIL read_pop_empty: got %h expected %h", dut_vec(), mdl_vec());
      end else n_pass++;
      n_checks++;
   endtask

   task automatic test_overflow();
      int ovf_cnt;
      int n;
      logic [6:0] c;
      ovf_cnt = 0;
      for (int i = 0; i <= int'(DEPTH); i++) begin
         c = 7'h50 + 7'(i);
         key(1, c, 0);
         step(1); if (bus.overflow === 1'b1) ovf_cnt++;
         step(1); if (bus.overflow === 1'b1) ovf_cnt++;
      end
      key(0, c, 0);
      for (int i = 0; i < 3; i++) begin
         step(1); if (bus.overflow === 1'b1) ovf_cnt++;
      end
      if (ovf_cnt !== 1) begin
         $display("FAIL overflow_pulse: got %0d pulses expected 1", ovf_cnt);
      end else n_pass++;
      n_checks++;
      n = 0;
      while (bus.kbd_available === 1'b1 && n < int'(DEPTH) + 2) begin
         c = 7'h50 + 7'(n);
         if (bus.kbd_data !== {1'b0, c}) begin
            $display("FAIL overflow_order[%0d]: got %h expected %h", n, bus.kbd_data, c);
         end else n_pass++;
         n_checks++;
         read_one();
         n++;
      end
      if (n !== int'(DEPTH)) begin
         $display("FAIL overflow_count: got %0d entries expected %0d", n, DEPTH);
      end else n_pass++;
      n_checks++;
   endtask

   task automatic test_repeat();
      int  ticks;
      int  n;
      logic c;
      key(1, 7'h20, 1);
      step(1);
      ticks = 0;
      while (ticks < 12) begin
         c = ($urandom_range(0, 2) != 0);
         if (c && ticks == 10) key(0, 7'h20, 1);
         step(c);
         if (c) ticks++;
         if (dut_vec() !== mdl_vec()) begin
            $display("FAIL repeat_step t%0d: got %h expected %h", ticks, dut_vec(), mdl_vec());
         end else n_pass++;
         n_checks++;
      end
      for (int i = 0; i < 6; i++) step(1);
      if (bus.keydown !== 1'b0) begin
         $display("FAIL repeat_break: keydown got %b expected 0", bus.keydown);
      end else n_pass++;
      n_checks++;
      n = 0;
      while (bus.kbd_available === 1'b1 && n < int'(DEPTH) + 2) begin
         if ({bus.kbd_data, bus.kbd_ar2} !== {8'h20, 1'b1}) begin
            $display("FAIL repeat_entry[%0d]: got %h/%b expected 20/1", n, bus.kbd_data,
                     bus.kbd_ar2);
         end else n_pass++;
         n_checks++;
         read_one();
         n++;
      end
      if (n !== 5) begin
         $display("FAIL repeat_count: got %0d entries expected 5", n);
      end else n_pass++;
      n_checks++;
   endtask

   task automatic test_nonheld_break();
      int n;
      key(1, 7'h20, 0);
      step(1);
      for (int t = 0; t < 10; t++) begin
         if (t == 1) key(0, 7'h33, 0);
         if (t == 8) key(0, 7'h20, 0);
         step(1);
         if (t == 3 && bus.keydown !== 1'b1) begin
            $display("FAIL nonheld_keydown: got %b expected 1", bus.keydown);
         end else if (t == 3) n_pass++;
         if (t == 3) n_checks++;
      end
      step(1); step(1);
      n = 0;
      while (bus.kbd_available === 1'b1 && n < int'(DEPTH) + 2) begin
         read_one();
         n++;
      end
      if (n !== 4) begin
         $display("FAIL nonheld_count: got %0d entries expected 4", n);
      end else n_pass++;
      n_checks++;
   endtask

   task automatic test_reset_during_repeat();
      int bad;
      key(1, 7'h55, 0);
      step(1);
      for (int t = 0; t < 8; t++) step(1);
      if (bus.kbd_available !== 1'b1) begin
         $display("FAIL rstrep_pre: avail got %b expected 1", bus.kbd_available);
      end else n_pass++;
      n_checks++;
      rst = 1'b1;
      step(1);
      if (dut_vec() !== 12'h000) begin
         $display("FAIL rstrep_outputs: got %h expected %h", dut_vec(), 12'h000);
      end else n_pass++;
      n_checks++;
      rst = 1'b0;
      bad = 0;
      for (int t = 0; t < 12; t++) begin
         step(1);
         if (bus.kbd_available !== 1'b0 || bus.keydown !== 1'b0) bad++;
      end
      if (bad !== 0) begin
         $display("FAIL rstrep_no_push: got %0d bad cycles expected 0", bad);
      end else n_pass++;
      n_checks++;
   endtask

   task automatic test_random();
      logic [6:0] codes [4];
      codes[0] = 7'h20; codes[1] = 7'h21; codes[2] = 7'h33; codes[3] = 7'h7f;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 5) == 0) bus.read_kbd = ~bus.read_kbd;
         if ($urandom_range(0, 9) == 0)
            key($urandom_range(0, 1) == 1, codes[$urandom_range(0, 3)], $urandom_range(0, 1) == 1);
         step($urandom_range(0, 3) != 0);
         if (dut_vec() !== mdl_vec()) begin
            $display("FAIL random cyc %0d: got %h expected %h", cyc, dut_vec(), mdl_vec());
         end else n_pass++;
         n_checks++;
      end
      rst = 1'b0;
      bus.read_kbd = 1'b0;
   endtask

   initial begin
      bus.key_strobe = 1'b0;
      bus.key_make   = 1'b0;
      bus.key_code   = '0;
      bus.key_ar2    = 1'b0;
      bus.read_kbd   = 1'b0;
      test_reset();
      test_single_make();
      test_read_pop();
      test_overflow();
      test_repeat();
      test_nonheld_break();
      test_reset_during_repeat();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
